// File: rtl/spi_regbank_slave.sv
// SPI slave that bridges an external SPI master to an on-chip register bank.
// SCLK, SSEL and MOSI are oversampled on CLK; all state runs in the CLK domain.
module spi_regbank_slave #(
  parameter int   DATA_WIDTH     = 8,
  parameter int   ADDRESS_WIDTH  = 5,
  parameter logic CPOL           = 1'b0,
  parameter logic CPHA           = 1'b0,
  parameter int   AUTO_INCREMENT = 1,
  parameter int   SYNC_STAGES    = 2
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     SSEL,
  input  logic                     SCLK,
  input  logic                     MOSI,
  output logic                     MISO,
  input  logic [DATA_WIDTH-1:0]    STATUS,
  output logic [ADDRESS_WIDTH-1:0] ADDRESS,
  input  logic [DATA_WIDTH-1:0]    READ_DATA,
  output logic                     RD_STROBE,
  output logic [DATA_WIDTH-1:0]    WRITE_DATA,
  output logic                     WREN,
  output logic                     START,
  output logic                     FRAME_END
);

  localparam int CNT_W = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [ADDRESS_WIDTH-1:0] ADDR_STEP =
    (AUTO_INCREMENT != 0) ? ADDRESS_WIDTH'(1) : ADDRESS_WIDTH'(0);

  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_CMD   = 2'b01;
  localparam logic [1:0] ST_READ  = 2'b10;
  localparam logic [1:0] ST_WRITE = 2'b11;

  logic [SYNC_STAGES-1:0]   sclk_sync_r;
  logic [SYNC_STAGES-1:0]   ssel_sync_r;
  logic [SYNC_STAGES-1:0]   mosi_sync_r;
  logic                     sclk_prev_r;
  logic                     ssel_prev_r;
  logic [1:0]               state_r;
  logic [CNT_W-1:0]         bit_cnt_r;
  logic [DATA_WIDTH-2:0]    rx_r;
  logic [DATA_WIDTH-1:0]    tx_r;
  logic [DATA_WIDTH-1:0]    next_word_r;
  logic                     load_pend_r;
  logic                     rd_capture_r;
  logic [ADDRESS_WIDTH-1:0] address_r;
  logic [DATA_WIDTH-1:0]    write_data_r;
  logic                     wren_r;
  logic                     rd_strobe_r;
  logic                     start_r;
  logic                     frame_end_r;

  logic                     sclk_s;
  logic                     ssel_s;
  logic                     mosi_s;
  logic                     lead_s;
  logic                     trail_s;
  logic                     sample_s;
  logic                     shift_s;
  logic                     ssel_rise_s;
  logic [DATA_WIDTH-1:0]    word_s;
  logic                     word_done_s;
  logic                     miso_oe_s;

  assign sclk_s      = sclk_sync_r[SYNC_STAGES-1];
  assign ssel_s      = ssel_sync_r[SYNC_STAGES-1];
  assign mosi_s      = mosi_sync_r[SYNC_STAGES-1];
  assign lead_s      = (sclk_prev_r == CPOL) && (sclk_s != CPOL);
  assign trail_s     = (sclk_prev_r != CPOL) && (sclk_s == CPOL);
  assign sample_s    = CPHA ? trail_s : lead_s;
  assign shift_s     = CPHA ? lead_s : trail_s;
  assign ssel_rise_s = !ssel_prev_r && ssel_s;
  assign word_s      = {rx_r, mosi_s};
  // A word finishing in the same CLK as the SSEL rise is dropped.
  assign word_done_s = sample_s && (bit_cnt_r == LAST_BIT) && !ssel_s && (state_r != ST_IDLE);
  assign miso_oe_s   = (state_r == ST_CMD) || (state_r == ST_READ);

  assign MISO       = miso_oe_s ? tx_r[DATA_WIDTH-1] : 1'bz;
  assign ADDRESS    = address_r;
  assign WRITE_DATA = write_data_r;
  assign WREN       = wren_r;
  assign RD_STROBE  = rd_strobe_r;
  assign START      = start_r;
  assign FRAME_END  = frame_end_r;

  // Synchronisers for the SPI pins, reset to their idle levels.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sclk_sync_r <= {SYNC_STAGES{CPOL}};
      ssel_sync_r <= {SYNC_STAGES{1'b1}};
      mosi_sync_r <= {SYNC_STAGES{1'b0}};
    end else begin
      sclk_sync_r <= {sclk_sync_r[SYNC_STAGES-2:0], SCLK};
      ssel_sync_r <= {ssel_sync_r[SYNC_STAGES-2:0], SSEL};
      mosi_sync_r <= {mosi_sync_r[SYNC_STAGES-2:0], MOSI};
    end
  end

  // Frame FSM, shift registers, address counter and register-bank strobes.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sclk_prev_r  <= CPOL;
      ssel_prev_r  <= 1'b1;
      state_r      <= ST_IDLE;
      bit_cnt_r    <= CNT_ZERO;
      rx_r         <= {(DATA_WIDTH-1){1'b0}};
      tx_r         <= {DATA_WIDTH{1'b0}};
      next_word_r  <= {DATA_WIDTH{1'b0}};
      load_pend_r  <= 1'b0;
      rd_capture_r <= 1'b0;
      address_r    <= {ADDRESS_WIDTH{1'b0}};
      write_data_r <= {DATA_WIDTH{1'b0}};
      wren_r       <= 1'b0;
      rd_strobe_r  <= 1'b0;
      start_r      <= 1'b0;
      frame_end_r  <= 1'b0;
    end else begin
      sclk_prev_r  <= sclk_s;
      ssel_prev_r  <= ssel_s;
      frame_end_r  <= ssel_rise_s;
      wren_r       <= 1'b0;
      rd_strobe_r  <= 1'b0;
      start_r      <= 1'b0;
      rd_capture_r <= rd_strobe_r;
      // The bank answers one CLK after the strobe; hold it until the next load edge.
      if (rd_capture_r) begin
        next_word_r <= READ_DATA;
      end
      if (wren_r) begin
        address_r <= address_r + ADDR_STEP;
      end
      case (state_r)
        ST_IDLE: begin
          if (!ssel_s) begin
            tx_r        <= STATUS;
            bit_cnt_r   <= CNT_ZERO;
            load_pend_r <= 1'b0;
            state_r     <= ST_CMD;
          end
        end
        default: begin
          if (ssel_s) begin
            state_r     <= ST_IDLE;
            load_pend_r <= 1'b0;
          end else begin
            if (sample_s) begin
              rx_r      <= word_s[DATA_WIDTH-2:0];
              bit_cnt_r <= (bit_cnt_r == LAST_BIT) ? CNT_ZERO : bit_cnt_r + CNT_ONE;
            end
            // With CPHA=1 the first leading edge of a word presents the MSB already loaded.
            if (shift_s) begin
              if (load_pend_r) begin
                tx_r        <= next_word_r;
                load_pend_r <= 1'b0;
              end else if (!(CPHA && (bit_cnt_r == CNT_ZERO))) begin
                tx_r <= {tx_r[DATA_WIDTH-2:0], 1'b0};
              end
            end
            if (word_done_s) begin
              case (state_r)
                ST_CMD: begin
                  address_r <= word_s[ADDRESS_WIDTH-1:0];
                  start_r   <= 1'b1;
                  if (word_s[DATA_WIDTH-1]) begin
                    state_r <= ST_WRITE;
                  end else begin
                    rd_strobe_r <= 1'b1;
                    load_pend_r <= 1'b1;
                    state_r     <= ST_READ;
                  end
                end
                ST_READ: begin
                  address_r   <= address_r + ADDR_STEP;
                  rd_strobe_r <= 1'b1;
                  load_pend_r <= 1'b1;
                end
                ST_WRITE: begin
                  write_data_r <= word_s;
                  wren_r       <= 1'b1;
                end
                default: begin
                  state_r <= ST_IDLE;
                end
              endcase
            end
          end
        end
      endcase
    end
  end

endmodule
